triple_compare_sequencer: RTL and testbench

- Stream sequencer for the 16-bit three-input compare datapath:
  - collects 16-bit words from a valid/ready input stream into triples (A, B, C, in arrival order);
  - runs one compare cycle on each triple;
  - holds the registered result on a valid/ready output until it is consumed.
- Sits between a sample source and any consumer of largest/smallest/equality results.
- Lets one compare datapath serve a continuous word stream without external sequencing.

---
 rtl/triple_compare_sequencer.sv | 165 ++++++++++++++++
 tb/tb_triple_compare_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triple_compare_sequencer.sv
// triple_compare_sequencer: groups a word stream into A/B/C triples,
// compares each once, holds result. Signed mode: TRIPLE_CMP_SIGNED_EN.
module triple_compare_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_largest,
  output logic [1:0]  out_smallest,
  output logic [2:0]  out_eq,
  output logic        out_all_equal,
  output logic [15:0] out_max,
  output logic [15:0] out_min
);

  typedef enum logic [1:0] {
    COLLECT,
    COMPARE,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nx;
  logic        accept;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;

  function automatic logic gt(
    input logic [15:0] x,
    input logic [15:0] y
  );
`ifdef TRIPLE_CMP_SIGNED_EN
    return $signed(x) > $signed(y);
`else
    return x > y;
`endif
  endfunction

  logic        gt_ab, gt_ba;
  logic        gt_ac, gt_ca;
  logic        gt_bc, gt_cb;
  logic [15:0] max_ab, min_ab;
  logic [15:0] max_v, min_v;
  logic [1:0]  lg_v, sm_v;
  logic [2:0]  eq_v;

  assign gt_ab  = gt(a, b);
  assign gt_ba  = gt(b, a);
  assign gt_ac  = gt(a, c);
  assign gt_ca  = gt(c, a);
  assign gt_bc  = gt(b, c);
  assign gt_cb  = gt(c, b);
  assign max_ab = gt_ab ? a : b;
  assign min_ab = gt_ab ? b : a;
  assign max_v  = gt(c, max_ab) ? c : max_ab;
  assign min_v  = gt(min_ab, c) ? c : min_ab;
  assign eq_v   = {a == c, b == c, a == b};

  // index of a strictly-greatest / strictly-least input, else tie code
  always_comb begin
    lg_v = 2'b11;
    sm_v = 2'b11;
    unique case (1'b1)
      gt_ab & gt_ac: lg_v = 2'b00;
      gt_ba & gt_bc: lg_v = 2'b01;
      gt_ca & gt_cb: lg_v = 2'b10;
      default: ;
    endcase
    unique case (1'b1)
      gt_ba & gt_ca: sm_v = 2'b00;
      gt_ab & gt_cb: sm_v = 2'b01;
      gt_ac & gt_bc: sm_v = 2'b10;
      default: ;
    endcase
  end

  // next-state, word counter and handshake; clear overrides all
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_ready = 1'b0;
    accept   = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          if (cnt == 2'd2) begin
            cnt_nx   = 2'd0;
            state_nx = COMPARE;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
      end
      COMPARE: state_nx = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nx = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
    if (clear) begin
      state_nx = COLLECT;
      cnt_nx   = 2'd0;
      accept   = 1'b0;
    end
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // operand capture in arrival order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (accept) begin
      unique case (cnt)
        2'd0:    a <= in_data;
        2'd1:    b <= in_data;
        default: c <= in_data;
      endcase
    end
  end

  // result registers load once per triple; clear leaves them intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_largest   <= 2'b11;
      out_smallest  <= 2'b11;
      out_eq        <= 3'b000;
      out_all_equal <= 1'b0;
      out_max       <= '0;
      out_min       <= '0;
    end else if (state == COMPARE && !clear) begin
      out_largest   <= lg_v;
      out_smallest  <= sm_v;
      out_eq        <= eq_v;
      out_all_equal <= &eq_v;
      out_max       <= max_v;
      out_min       <= min_v;
    end
  end

  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_triple_compare_sequencer.sv
// tb_triple_compare_sequencer: directed + random stimulus against a
// value-level reference model of the triple compare.
module tb_triple_compare_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_largest;
  logic [1:0]  out_smallest;
  logic [2:0]  out_eq;
  logic        out_all_equal;
  logic [15:0] out_max;
  logic [15:0] out_min;

  int checks = 0;
  int errors = 0;

  localparam logic [39:0] RST_RES =
    {2'b11, 2'b11, 3'b000, 1'b0, 16'h0, 16'h0};

  logic [39:0] res;
  assign res = {out_largest, out_smallest, out_eq,
                out_all_equal, out_max, out_min};

  triple_compare_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_largest  (out_largest),
    .out_smallest (out_smallest),
    .out_eq       (out_eq),
    .out_all_equal(out_all_equal),
    .out_max      (out_max),
    .out_min      (out_min)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] model(
    input logic [15:0] x0,
    input logic [15:0] x1,
    input logic [15:0] x2
  );
    logic [15:0] w[3];
    int          v[3];
    int          mx, mn, nmx, nmn;
    logic [1:0]  li, si;
    logic [15:0] mxw, mnw;
    logic [2:0]  eq;
    w[0] = x0;
    w[1] = x1;
    w[2] = x2;
    for (int i = 0; i < 3; i++) begin
`ifdef TRIPLE_CMP_SIGNED_EN
      v[i] = int'($signed(w[i]));
`else
      v[i] = int'(w[i]);
`endif
    end
    mx = v[0];
    mn = v[0];
    for (int i = 1; i < 3; i++) begin
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
    nmx = 0; nmn = 0;
    li = 2'b11; si = 2'b11;
    mxw = '0; mnw = '0;
    for (int i = 0; i < 3; i++) begin
      if (v[i] == mx) begin
        nmx++; li = i[1:0]; mxw = w[i];
      end
      if (v[i] == mn) begin
        nmn++; si = i[1:0]; mnw = w[i];
      end
    end
    if (nmx > 1) li = 2'b11;
    if (nmn > 1) si = 2'b11;
    eq = {w[0] == w[2], w[1] == w[2], w[0] == w[1]};
    return {li, si, eq, &eq, mxw, mnw};
  endfunction

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_word: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_triple(
    input logic [15:0] x0,
    input logic [15:0] x1,
    input logic [15:0] x2
  );
    send_word(x0);
    send_word(x1);
    send_word(x2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res !== RST_RES || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: res=%h ov=%b required %h 0",
               res, out_valid, RST_RES);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [39:0] exp;
    out_ready = 1'b1;
    send_triple(16'h0010, 16'h0020, 16'h0030);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL compare_cycle: ov=%b ir=%b required 0 0",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    exp = {2'b10, 2'b00, 3'b000, 1'b0, 16'h0030, 16'h0010};
    checks++;
    if (out_valid !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL ascend: ov=%b res=%h required 1 %h",
               out_valid, res, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pulse_end: ov=%b ir=%b required 0 1",
               out_valid, in_ready);
    end

    send_triple(16'h1234, 16'h1234, 16'h1234);
    @(posedge clk); #1;
    exp = {2'b11, 2'b11, 3'b111, 1'b1, 16'h1234, 16'h1234};
    checks++;
    if (out_valid !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL all_equal: ov=%b res=%h required 1 %h",
               out_valid, res, exp);
    end
    @(posedge clk); #1;

    out_ready = 1'b0;
    send_triple(16'h0050, 16'h0050, 16'h0001);
    @(posedge clk); #1;
    exp = {2'b11, 2'b10, 3'b001, 1'b0, 16'h0050, 16'h0001};
    in_data  = 16'hDEAD;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== exp) begin
        errors++;
        $display("FAIL hold_%0d: ov=%b ir=%b res=%h required 1 0 %h",
                 i, out_valid, in_ready, res, exp);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: ov=%b ir=%b required 0 1",
               out_valid, in_ready);
    end

    send_triple(16'h8000, 16'h0001, 16'h7FFF);
    @(posedge clk); #1;
`ifdef TRIPLE_CMP_SIGNED_EN
    exp = {2'b10, 2'b00, 3'b000, 1'b0, 16'h7FFF, 16'h8000};
`else
    exp = {2'b00, 2'b01, 3'b000, 1'b0, 16'h8000, 16'h0001};
`endif
    checks++;
    if (out_valid !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL sign_mode: ov=%b res=%h required 1 %h",
               out_valid, res, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    logic [39:0] exp;
    out_ready = 1'b1;
    send_word(16'h0AAA);
    send_word(16'h0BBB);
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: ir=%b ov=%b required 1 0",
               in_ready, out_valid);
    end
    send_triple(16'h0003, 16'h0002, 16'h0001);
    @(posedge clk); #1;
    exp = {2'b00, 2'b10, 3'b000, 1'b0, 16'h0003, 16'h0001};
    checks++;
    if (out_valid !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL clear_triple: ov=%b res=%h required 1 %h",
               out_valid, res, exp);
    end
    @(posedge clk); #1;

    out_ready = 1'b0;
    send_triple(16'h0007, 16'h0007, 16'h0009);
    @(posedge clk); #1;
    exp = model(16'h0007, 16'h0007, 16'h0009);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL clear_hold: ov=%b ir=%b res=%h required 0 1 %h",
               out_valid, in_ready, res, exp);
    end

    send_triple(16'h0001, 16'h0002, 16'h0003);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL clear_compare: ov=%b ir=%b res=%h required 0 1 %h",
               out_valid, in_ready, res, exp);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool[5];
    logic [15:0] w[3];
    logic [39:0] exp;
    int          d;
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h8000;
    pool[3] = 16'h7FFF; pool[4] = 16'hFFFF;
    out_ready = 1'b0;
    for (int t = 0; t < 30; t++) begin
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 2) == 0)
          w[j] = pool[$urandom_range(0, 4)];
        else
          w[j] = 16'($urandom());
        if (j > 0 && $urandom_range(0, 3) == 0)
          w[j] = w[j-1];
      end
      exp = model(w[0], w[1], w[2]);
      for (int j = 0; j < 3; j++) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        d = $urandom_range(0, 2);
        repeat (d) begin
          @(posedge clk); #1;
        end
        send_word(w[j]);
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_latency_%0d: ov=%b required 0", t, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || res !== exp) begin
        errors++;
        $display("FAIL rnd_result_%0d: ov=%b res=%h required 1 %h",
                 t, out_valid, res, exp);
      end
      in_valid = 1'b1;
      in_data  = 16'($urandom());
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== exp) begin
          errors++;
          $display("FAIL rnd_hold_%0d: ov=%b ir=%b res=%h required 1 0 %h",
                   t, out_valid, in_ready, res, exp);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd_release_%0d: ov=%b ir=%b required 0 1",
                 t, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [39:0] exp;
    int          acc = 0;
    int          last_third = -10;
    int          results = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int e = 0; e < 20; e++) begin
      in_data = 16'($urandom());
      if (in_ready) begin
        q.push_back(in_data);
        acc++;
        if (acc % 3 == 0) last_third = e;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        results++;
        exp = '0;
        if (q.size() >= 3) exp = model(q[0], q[1], q[2]);
        checks++;
        if (e != last_third + 1 || q.size() < 3 || res !== exp) begin
          errors++;
          $display("FAIL b2b_edge_%0d: third=%0d res=%h required %0d %h",
                   e, last_third, res, e - 1, exp);
        end
        repeat (3) if (q.size() > 0) void'(q.pop_front());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (results != 4) begin
      errors++;
      $display("FAIL b2b_count: results=%0d required 4", results);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] exp;
    out_ready = 1'b1;
    send_triple(16'd100, 16'd200, 16'd300);
    rst_n = 1'b0;
    #1;
    checks++;
    if (res !== RST_RES || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: res=%h ov=%b ir=%b required %h 0 1",
               res, out_valid, in_ready, RST_RES);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rel: ov=%b ir=%b required 0 1",
               out_valid, in_ready);
    end
    send_triple(16'h0005, 16'h0009, 16'h0005);
    @(posedge clk); #1;
    exp = model(16'h0005, 16'h0009, 16'h0005);
    checks++;
    if (out_valid !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL reset_mid_triple: ov=%b res=%h required 1 %h",
               out_valid, res, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_clear();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
